lc3_mem_unit: RTL and testbench

Parametrised memory-access unit for the LC-3 datapath. It replaces the fixed MAR/MDR/MEM_MUX/RAM-ready path with a registered MAR and MDR and a request/acknowledge port to external memory. It decodes a memory-mapped I/O window, applies a timeout guard, and gives the control FSM a clean READY handshake. It sits between the shared BUS, the control FSM signals (LD_MAR, LD_MDR, MIO_EN, WE) and the memory/device fabric.

---
 rtl/lc3_mem_unit_if.sv | 30 +++
 rtl/lc3_mem_unit.sv | 123 ++++++++++++
 tb/tb_lc3_mem_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_mem_unit_if.sv
// Memory/device fabric port of the LC-3 memory-access unit.
// One request/ack pair each for RAM and the I/O window.
interface lc3_mem_unit_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic              mem_req;
   logic              io_req;
   logic              acc_we;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic              io_ack;
   logic [DATA_W-1:0] io_rdata;

   modport master (
      output mem_req, io_req, acc_we,
      output acc_addr, acc_wdata,
      input  mem_ack, mem_rdata,
      input  io_ack, io_rdata
   );

   modport slave (
      input  mem_req, io_req, acc_we,
      input  acc_addr, acc_wdata,
      output mem_ack, mem_rdata,
      output io_ack, io_rdata
   );
endinterface

// File: rtl/lc3_mem_unit.sv
// LC-3 MAR/MDR with request/ack memory port, I/O window decode,
// timeout guard and a READY handshake for the control FSM.
module lc3_mem_unit #(
   parameter int               DATA_W  = 16,
   parameter int               ADDR_W  = 16,
   parameter logic [ADDR_W-1:0] IO_BASE = 16'hFE00,
   parameter int               TIMEOUT = 64,
   parameter int               CNT_W   = 7
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DATA_W-1:0] bus_in,
   input  logic              LD_MAR,
   input  logic              LD_MDR,
   input  logic              MIO_EN,
   input  logic              WE,
   output logic [ADDR_W-1:0] mar_out,
   output logic [DATA_W-1:0] mdr_out,
   output logic              READY,
   output logic              ERR,
   lc3_mem_unit_if.master    mem
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] mar_q, mar_d;
   logic [DATA_W-1:0] mdr_q, mdr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              we_q, we_d;
   logic              io_q, io_d;
   logic              err_q, err_d;

   logic              ack;
   logic [DATA_W-1:0] rdata;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         mar_q   <= '0;
         mdr_q   <= '0;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         io_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mar_q   <= mar_d;
         mdr_q   <= mdr_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         io_q    <= io_d;
         err_q   <= err_d;
      end
   end

   // Only the port selected at request time is listened to.
   assign ack   = io_q ? mem.io_ack : mem.mem_ack;
   assign rdata = io_q ? mem.io_rdata : mem.mem_rdata;

   always_comb begin
      state_d = state_q;
      mar_d   = mar_q;
      mdr_d   = mdr_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      io_d    = io_q;
      err_d   = err_q;

      // Bus loads are frozen while a request is outstanding.
      if (state_q != REQ) begin
         if (LD_MAR)
            mar_d = bus_in[ADDR_W-1:0];
         if (LD_MDR && !MIO_EN)
            mdr_d = bus_in;
      end

      unique case (state_q)
         IDLE: begin
            if (MIO_EN) begin
               state_d = REQ;
               we_d    = WE;
               io_d    = (mar_q >= IO_BASE);
               cnt_d   = '0;
            end
         end
         REQ: begin
            if (!MIO_EN) begin
               state_d = IDLE;
            end else if (ack) begin
               if (!we_q && LD_MDR)
                  mdr_d = rdata;
               state_d = DONE;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (!MIO_EN)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign mar_out       = mar_q;
   assign mdr_out       = mdr_q;
   assign READY         = (state_q == DONE);
   assign ERR           = err_q;
   assign mem.mem_req   = (state_q == REQ) && !io_q;
   assign mem.io_req    = (state_q == REQ) && io_q;
   assign mem.acc_we    = (state_q == REQ) && we_q;
   assign mem.acc_addr  = mar_q;
   assign mem.acc_wdata = mdr_q;

endmodule

// File: tb/tb_lc3_mem_unit.sv
// Directed bench for lc3_mem_unit: vector table of single accesses
// plus hand sequences for hold, abort and mid-request reset.
module tb_lc3_mem_unit;

   logic        CLK;
   logic        RST;
   logic [15:0] bus_in;
   logic        LD_MAR, LD_MDR, MIO_EN, WE;
   logic [15:0] mar_out, mdr_out;
   logic        READY, ERR;

   int n_tests = 0;
   int n_fail  = 0;

   lc3_mem_unit_if #(.DATA_W(16), .ADDR_W(16)) mif ();

   lc3_mem_unit #(
      .DATA_W (16),
      .ADDR_W (16),
      .IO_BASE(16'hFE00),
      .TIMEOUT(4),
      .CNT_W  (3)
   ) dut (
      .CLK    (CLK),
      .RST    (RST),
      .bus_in (bus_in),
      .LD_MAR (LD_MAR),
      .LD_MDR (LD_MDR),
      .MIO_EN (MIO_EN),
      .WE     (WE),
      .mar_out(mar_out),
      .mdr_out(mdr_out),
      .READY  (READY),
      .ERR    (ERR),
      .mem    (mif)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [15:0] addr;
      logic        we;
      logic [15:0] wdata;
      int          lat;
      logic [15:0] rdata;
      logic        ldmdr;
      logic        exp_io;
      int          exp_req;
      int          exp_rdy;
      logic [15:0] exp_mdr;
      logic        exp_err;
   } vec_t;

   vec_t vt[9];

   task automatic tick();
      @(negedge CLK);
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic load_mar(input logic [15:0] a);
      bus_in = a;
      LD_MAR = 1'b1;
      tick();
      LD_MAR = 1'b0;
   endtask

   task automatic run_vec(input int i, input vec_t v);
      int          reqs;
      int          rdy_at;
      logic        mem_seen, io_seen;
      logic [15:0] a_addr, a_wdata;
      logic        a_we;
      reqs = 0; rdy_at = 0;
      mem_seen = 0; io_seen = 0;
      a_addr = '0; a_wdata = '0; a_we = 0;
      load_mar(v.addr);
      if (v.we) begin
         bus_in = v.wdata;
         LD_MDR = 1'b1;
         tick();
         LD_MDR = 1'b0;
      end
      MIO_EN = 1'b1;
      WE     = v.we;
      LD_MDR = v.ldmdr;
      if (v.exp_io) begin
         mif.mem_ack   = 1'b1;
         mif.mem_rdata = 16'hDEAD;
      end
      for (int n = 1; n <= 20; n++) begin
         tick();
         mif.io_ack = 1'b0;
         if (!v.exp_io) mif.mem_ack = 1'b0;
         if (READY) begin
            rdy_at = n;
            break;
         end
         if (mif.mem_req) mem_seen = 1'b1;
         if (mif.io_req) io_seen = 1'b1;
         if (mif.mem_req || mif.io_req) begin
            reqs++;
            if (reqs == 1) begin
               a_addr  = mif.acc_addr;
               a_wdata = mif.acc_wdata;
               a_we    = mif.acc_we;
            end
            if (reqs == v.lat) begin
               if (v.exp_io) begin
                  mif.io_ack   = 1'b1;
                  mif.io_rdata = v.rdata;
               end else begin
                  mif.mem_ack   = 1'b1;
                  mif.mem_rdata = v.rdata;
               end
            end
         end
      end
      chk($sformatf("v%0d req_cycles", i), reqs, v.exp_req);
      chk($sformatf("v%0d mem_seen", i), mem_seen, !v.exp_io);
      chk($sformatf("v%0d io_seen", i), io_seen, v.exp_io);
      chk($sformatf("v%0d ready_at", i), rdy_at, v.exp_rdy);
      chk($sformatf("v%0d mdr", i), mdr_out, v.exp_mdr);
      chk($sformatf("v%0d err", i), ERR, v.exp_err);
      chk($sformatf("v%0d acc_addr", i), a_addr, v.addr);
      chk($sformatf("v%0d acc_we", i), a_we, v.we);
      if (v.we)
         chk($sformatf("v%0d acc_wdata", i), a_wdata, v.wdata);
      MIO_EN = 1'b0;
      LD_MDR = 1'b0;
      WE     = 1'b0;
      mif.mem_ack = 1'b0;
      mif.io_ack  = 1'b0;
      tick();
      chk($sformatf("v%0d ready_drop", i), READY, 1'b0);
   endtask

   initial begin
      //          addr      we wdata    lat rdata    ldm io req rdy mdr      err
      vt[0] = '{16'h3000, 0, 16'h0000, 3, 16'h1234, 1, 0, 3, 4, 16'h1234, 0};
      vt[1] = '{16'h4000, 1, 16'hBEEF, 1, 16'h0000, 0, 0, 1, 2, 16'hBEEF, 0};
      vt[2] = '{16'hFE02, 0, 16'h0000, 2, 16'h8000, 1, 1, 2, 3, 16'h8000, 0};
      vt[3] = '{16'hFDFF, 0, 16'h0000, 1, 16'h5555, 1, 0, 1, 2, 16'h5555, 0};
      vt[4] = '{16'h0100, 0, 16'h0000, 4, 16'h0A0A, 1, 0, 4, 5, 16'h0A0A, 0};
      vt[5] = '{16'h0200, 0, 16'h0000, 0, 16'h0000, 1, 0, 4, 5, 16'h0A0A, 1};
      vt[6] = '{16'h0300, 0, 16'h0000, 2, 16'h7777, 1, 0, 2, 3, 16'h7777, 1};
      vt[7] = '{16'hFFFF, 0, 16'h0000, 1, 16'h0001, 1, 1, 1, 2, 16'h0001, 1};
      vt[8] = '{16'h1000, 0, 16'h0000, 1, 16'h9999, 0, 0, 1, 2, 16'h0001, 1};

      RST = 1'b0;
      bus_in = '0;
      LD_MAR = 0; LD_MDR = 0; MIO_EN = 0; WE = 0;
      mif.mem_ack = 0; mif.mem_rdata = '0;
      mif.io_ack = 0; mif.io_rdata = '0;
      tick();
      tick();
      chk("reset_regs", {mar_out, mdr_out}, 32'h0);
      chk("reset_flags",
          {READY, ERR, mif.mem_req, mif.io_req, mif.acc_we}, 5'b0);
      RST = 1'b1;
      tick();

      for (int i = 0; i < 9; i++)
         run_vec(i, vt[i]);

      // MAR loaded in the same cycle as MIO_EN: decode uses the old MAR
      load_mar(16'h0500);
      bus_in = 16'hFE00;
      LD_MAR = 1'b1;
      MIO_EN = 1'b1;
      LD_MDR = 1'b1;
      tick();
      chk("same_cycle_mar", mar_out, 16'hFE00);
      chk("same_cycle_mem", {mif.mem_req, mif.io_req}, 2'b10);
      bus_in = 16'h1111;
      tick();
      LD_MAR = 1'b0;
      chk("ld_mar_in_req", mar_out, 16'hFE00);
      mif.mem_ack   = 1'b1;
      mif.mem_rdata = 16'h2222;
      tick();
      mif.mem_ack = 1'b0;
      chk("hold_ready0", READY, 1'b1);
      chk("hold_mdr", mdr_out, 16'h2222);
      for (int n = 1; n <= 3; n++) begin
         tick();
         chk($sformatf("hold_ready%0d", n), READY, 1'b1);
         chk($sformatf("hold_noreq%0d", n),
             {mif.mem_req, mif.io_req}, 2'b00);
      end
      MIO_EN = 1'b0;
      LD_MDR = 1'b0;
      tick();
      chk("hold_release", READY, 1'b0);

      // FSM abort mid-request
      load_mar(16'h3000);
      MIO_EN = 1'b1;
      tick();
      chk("abort_req_on", mif.mem_req, 1'b1);
      tick();
      MIO_EN = 1'b0;
      tick();
      chk("abort_req_off", {mif.mem_req, READY}, 2'b00);
      tick();
      chk("abort_no_ready", READY, 1'b0);

      // Asynchronous reset while requesting
      load_mar(16'h3000);
      MIO_EN = 1'b1;
      tick();
      tick();
      chk("rst_pre_req", mif.mem_req, 1'b1);
      RST = 1'b0;
      #1;
      chk("rst_mid_req", {mif.mem_req, READY, ERR}, 3'b000);
      chk("rst_mid_regs", {mar_out, mdr_out}, 32'h0);
      MIO_EN = 1'b0;
      tick();
      RST = 1'b1;
      tick();
      chk("rst_idle", {mif.mem_req, mif.io_req, READY}, 3'b000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
